// File: rtl/prot_pkg.sv
// Shared definitions for the protection port: status bit positions, reply FSM states,
// and the floating-bus byte returned on empty reads when the FF underflow option is built.
package prot_pkg;

    localparam int unsigned STAT_AVAIL = 0;
    localparam int unsigned STAT_READY = 1;
    localparam int unsigned STAT_OVF   = 7;

    typedef enum logic {
        PR_IDLE,
        PR_BUSY
    } pr_state_e;

    localparam logic [7:0] UNDERFLOW_BYTE = 8'hFF;

endpackage

// File: rtl/prot_reply_fifo.sv
// Show-ahead reply FIFO: DEPTH entries (power of two), head presented combinationally.
// A push at full is accepted only when a pop frees the slot in the same cycle.
module prot_reply_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    assign head     = mem[rptr];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

endmodule

// File: rtl/rising_edge.sv
// Single-cycle pulse on the rising edge of a level input, using the registered previous value.
module rising_edge (
    input  logic clk_sys,
    input  logic reset,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/prot_reply.sv
// Read side of the protection port: reply FIFO, sticky overflow, and post-write busy window.
// Option macro PROT_REPLY_UNDERFLOW_FF_EN: empty reads return 8'hFF instead of the last popped byte.
module prot_reply
    import prot_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned BUSY_CYCLES = 64
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       wr,
    input  logic       rd,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic [7:0] dout,
    output logic [7:0] status
);

    localparam logic [7:0] BUSY_LOAD = 8'(BUSY_CYCLES - 1);

    logic       wr_re;
    logic       rd_re;
    logic [7:0] head;
    logic       empty;
    logic       overflow;
    logic       ovf;
    logic       ready;
    pr_state_e  state;
    pr_state_e  state_nxt;
    logic [7:0] busy_cnt;
    logic [7:0] busy_cnt_nxt;

    rising_edge u_wr_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .sig     (wr),
        .pulse   (wr_re)
    );

    rising_edge u_rd_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .sig     (rd),
        .pulse   (rd_re)
    );

    prot_reply_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (rd_re),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= PR_IDLE;
            busy_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
            if (overflow) begin
                ovf <= 1'b1;
            end
        end
    end

    // A write while busy restarts the window rather than extending it.
    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        ready        = 1'b0;
        case (state)
            PR_IDLE: begin
                ready = 1'b1;
                if (wr_re) begin
                    state_nxt    = PR_BUSY;
                    busy_cnt_nxt = BUSY_LOAD;
                end
            end
            PR_BUSY: begin
                if (wr_re) begin
                    busy_cnt_nxt = BUSY_LOAD;
                end else if (busy_cnt == '0) begin
                    state_nxt = PR_IDLE;
                end else begin
                    busy_cnt_nxt = busy_cnt - 1'b1;
                end
            end
        endcase
    end

`ifdef PROT_REPLY_UNDERFLOW_FF_EN
    assign dout = empty ? UNDERFLOW_BYTE : head;
`else
    logic [7:0] last_pop;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_pop <= '0;
        end else if (rd_re && !empty) begin
            last_pop <= head;
        end
    end

    assign dout = empty ? last_pop : head;
`endif

    always_comb begin
        status             = '0;
        status[STAT_OVF]   = ovf;
        status[STAT_READY] = ready;
        status[STAT_AVAIL] = ~empty;
    end

endmodule

// File: tb/tb_prot_reply.sv
// Self-checking bench for prot_reply (DEPTH=4, BUSY_CYCLES=4) with a reply-byte scoreboard queue.
module tb_prot_reply;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BUSY  = 4;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = '0;
    logic       full;
    logic [7:0] dout;
    logic [7:0] status;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  q[$];
    logic [7:0]  last_pop = 8'h00;

    prot_reply #(
        .DEPTH       (DEPTH),
        .BUSY_CYCLES (BUSY)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .wr        (wr),
        .rd        (rd),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .dout      (dout),
        .status    (status)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [7:0] uf_value();
`ifdef PROT_REPLY_UNDERFLOW_FF_EN
        return 8'hFF;
`else
        return last_pop;
`endif
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        last_pop = 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] d);
        push      = 1'b1;
        push_data = d;
        if (q.size() < DEPTH) q.push_back(d);
        tick();
        push = 1'b0;
    endtask

    task automatic cpu_read(output logic [7:0] got);
        got = dout;
        rd  = 1'b1;
        tick();
        rd = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (status !== 8'h02) begin errors++; $display("FAIL reset_status got %h exp %h", status, 8'h02); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++;
        if (dout !== uf_value()) begin errors++; $display("FAIL reset_dout got %h exp %h", dout, uf_value()); end
    endtask

    task automatic test_push_pop();
        logic [7:0] got, exp;
        apply_reset();
        push_byte(8'hA5);
        push_byte(8'h5A);
        checks++;
        if (status !== 8'h03) begin errors++; $display("FAIL pp_status got %h exp %h", status, 8'h03); end
        checks++;
        if (dout !== q[0]) begin errors++; $display("FAIL pp_head got %h exp %h", dout, q[0]); end
        for (int i = 0; i < 2; i++) begin
            cpu_read(got);
            exp = q.pop_front();
            last_pop = exp;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL pp_read%0d got %h exp %h", i, got, exp); end
        end
        checks++;
        if (status !== 8'h02) begin errors++; $display("FAIL pp_empty_status got %h exp %h", status, 8'h02); end
        checks++;
        if (dout !== uf_value()) begin errors++; $display("FAIL pp_underflow got %h exp %h", dout, uf_value()); end
    endtask

    task automatic test_busy(input bit retrig, input int unsigned exp_low);
        int unsigned low;
        apply_reset();
        checks++;
        if (status[1] !== 1'b1) begin errors++; $display("FAIL busy_idle_ready got %b exp 1", status[1]); end
        wr = 1'b1;
        tick();
        wr  = 1'b0;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            if (status[1] === 1'b1) break;
            low++;
            if (retrig && low == 2) wr = 1'b1;
            tick();
            wr = 1'b0;
        end
        checks++;
        if (low !== exp_low) begin errors++; $display("FAIL busy_low_cycles retrig=%0d got %0d exp %0d", retrig, low, exp_low); end
    endtask

    task automatic test_overflow();
        logic [7:0] got, exp;
        logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        apply_reset();
        foreach (vals[i]) push_byte(vals[i]);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
        checks++;
        if (status !== 8'h83) begin errors++; $display("FAIL ovf_status got %h exp %h", status, 8'h83); end
        for (int i = 0; i < 4; i++) begin
            cpu_read(got);
            exp = q.pop_front();
            last_pop = exp;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL ovf_read%0d got %h exp %h", i, got, exp); end
        end
        checks++;
        if (status !== 8'h82) begin errors++; $display("FAIL ovf_sticky got %h exp %h", status, 8'h82); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] got, exp;
        apply_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        got       = dout;
        push      = 1'b1;
        push_data = 8'h66;
        rd        = 1'b1;
        tick();
        push = 1'b0;
        rd   = 1'b0;
        exp = q.pop_front();
        last_pop = exp;
        q.push_back(8'h66);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL fpp_head got %h exp %h", got, exp); end
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL fpp_full got %b exp 1", full); end
        checks++;
        if (status !== 8'h03) begin errors++; $display("FAIL fpp_status got %h exp %h", status, 8'h03); end
        tick();
        for (int i = 0; i < 4; i++) begin
            cpu_read(got);
            exp = q.pop_front();
            last_pop = exp;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL fpp_read%0d got %h exp %h", i, got, exp); end
        end
    endtask

    task automatic test_rd_hold();
        logic [7:0] got, exp;
        apply_reset();
        push_byte(8'h77);
        push_byte(8'h88);
        got = dout;
        rd  = 1'b1;
        repeat (10) tick();
        rd = 1'b0;
        tick();
        exp = q.pop_front();
        last_pop = exp;
        checks++;
        if (got !== exp) begin errors++; $display("FAIL hold_first got %h exp %h", got, exp); end
        checks++;
        if (status !== 8'h03) begin errors++; $display("FAIL hold_status got %h exp %h", status, 8'h03); end
        checks++;
        if (dout !== q[0]) begin errors++; $display("FAIL hold_head got %h exp %h", dout, q[0]); end
        cpu_read(got);
        exp = q.pop_front();
        last_pop = exp;
        checks++;
        if (got !== exp) begin errors++; $display("FAIL hold_second got %h exp %h", got, exp); end
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        checks++;
        if (status !== 8'h01) begin errors++; $display("FAIL mid_busy_status got %h exp %h", status, 8'h01); end
        // push and wr edge alongside reset must both be overridden
        reset     = 1'b1;
        push      = 1'b1;
        push_data = 8'hEE;
        wr        = 1'b1;
        tick();
        reset = 1'b0;
        push  = 1'b0;
        wr    = 1'b0;
        q.delete();
        last_pop = 8'h00;
        checks++;
        if (status !== 8'h02) begin errors++; $display("FAIL rst_busy_status got %h exp %h", status, 8'h02); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL rst_busy_full got %b exp 0", full); end
        checks++;
        if (dout !== uf_value()) begin errors++; $display("FAIL rst_busy_dout got %h exp %h", dout, uf_value()); end
    endtask

    initial begin
        tick();
        test_reset();
        test_push_pop();
        test_busy(1'b0, BUSY);
        test_busy(1'b1, BUSY + 2);
        test_overflow();
        test_full_push_pop();
        test_rd_hold();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prot_reply.md
# prot_reply

Read side of the Express Raider protection port. The CPU writes command bytes to the protection data port; this block answers the CPU's reads of the data and status ports. Reply bytes come from the protection sequencer through a small FIFO, and a programmable busy window after each CPU write models the protection MCU's processing latency. It sits between the CPU read-data mux and the protection sequencer, alongside the write-side counter logic.

## Interface
Parameters:
- DEPTH, 4: reply FIFO entries; power of two, 2..16
- BUSY_CYCLES, 64: clk_sys cycles the ready bit stays low after a CPU write; 1..255

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- wr  in  1  CPU write strobe to the protection data port; level signal, edge-qualified
- rd  in  1  CPU read strobe of the protection data port; level signal, edge-qualified
- push  in  1  sequencer pushes push_data this cycle; single-cycle qualified
- push_data  in  8  reply byte
- full  out  1  FIFO holds DEPTH entries
- dout  out  8  CPU data-port read value
- status  out  8  CPU status-port read value: {ovf, 5'b0, ready, avail}

## Operation
- Edge detect:
  - wr_re is high in the cycle where wr=1 and the registered previous wr=0.
  - rd_re is formed the same way from rd.
  - Holding a strobe high produces exactly one event.
- State machine, two states:
  - IDLE: ready=1. On wr_re, go to BUSY and load busy_cnt with BUSY_CYCLES-1.
  - BUSY: ready=0. Decrement busy_cnt each cycle. When busy_cnt==0, return to IDLE on the next edge.
  - wr_re while in BUSY reloads busy_cnt (retrigger) and stays in BUSY.
- FIFO:
  - Write pointer, read pointer and occupancy count; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - A push when not full writes at the write pointer and increments it.
  - A push when full is dropped and sets the sticky ovf bit. ovf clears only on reset.
  - rd_re when not empty pops: the read pointer increments.
  - rd_re when empty is ignored.
  - Push and pop in the same cycle:
    - not full and not empty: both happen, count unchanged.
    - full: the pop frees a slot and the push is accepted, count unchanged, ovf not set.
    - empty: the push is accepted and the pop is ignored.
- dout:
  - When not empty, dout = head entry (combinational from memory at the read pointer).
  - When empty, dout = underflow value (see Configuration).
- avail = not empty. full = (count==DEPTH).
- Reset values: state IDLE, busy_cnt 0, pointers and count 0, ovf 0, last-popped register 8'h00. status=8'h02, full=0, dout=underflow value.

## Timing
- A wr edge in cycle N (wr_re high in N) gives ready=0 from cycle N+1 through N+BUSY_CYCLES inclusive, and ready=1 at N+BUSY_CYCLES+1.
- A push in cycle N gives avail=1 and an updated dout at N+1.
- A pop on rd_re in cycle N changes dout and avail at N+1. dout is stable through the cycle of the rd rising edge, so the CPU samples the pre-pop head.
- Reset asserted in any cycle, including mid-BUSY or with the FIFO full, gives reset values in the next cycle. reset takes priority over wr_re, rd_re and push in the same cycle.

## Configuration
- Macro PROT_REPLY_UNDERFLOW_FF_EN.
- Defined: empty-FIFO reads return 8'hFF, modelling a floating bus.
- Undefined: empty-FIFO reads return the last popped byte. That register resets to 8'h00 and loads the head on every pop.

## Structure
- Shared package prot_pkg holds:
  - status bit indices STAT_AVAIL=0, STAT_READY=1, STAT_OVF=7
  - the state enum {PR_IDLE, PR_BUSY}
  - the underflow constant 8'hFF
- Natural sub-module: prot_reply_fifo (DEPTH-parameterised storage, pointers, count, full/empty, show-ahead head output).
- Edge detection reuses the codebase's existing rising_edge cell, one instance each for wr and rd.

## Test plan
- Reset, default build → status=8'h02, dout=8'h00, full=0. With PROT_REPLY_UNDERFLOW_FF_EN → dout=8'hFF.
- Push 8'hA5, then 8'h5A → status=8'h03, dout=8'hA5. rd pulse → dout=8'h5A next cycle. Second rd pulse → status=8'h02, dout=8'h5A in the default build.
- BUSY_CYCLES=4, wr pulse → status bit1 low for exactly 4 cycles. A second wr after 2 low cycles → 4 more low cycles (6 total).
- DEPTH=4, push 11,22,33,44,55 → full=1, status=8'h83. Four pops return 11,22,33,44; 55 is lost.
- At full, push 66 and rd edge in the same cycle → count stays 4, ovf unchanged. Subsequent reads return 22,33,44,66.
- rd held high for 10 cycles with 2 entries → exactly one pop. Reset mid-BUSY with 3 entries → next cycle status=8'h02, full=0.
